bidir_bus_ctrl: RTL and testbench

Transaction sequencer for a half-duplex parallel pad bus built from bidirectional IO cells. It accepts single-word read/write requests on a valid/ready interface. For each request it drives the per-bit output-enable, output data and an output-only strobe pin through fixed setup/strobe/hold/turnaround phases, and captures read data from the pad inputs. It sits between a register-mapped peripheral and the bidirectional IO cell array at the FPGA top level.

---
 rtl/bidir_bus_ctrl.sv | 149 ++++++++++++++
 tb/tb_bidir_bus_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex pad bus sequencer: drives OE/data/strobe through setup, strobe, hold and
// turnaround phases for single-word reads and writes, and captures read data from the pads.
module bidir_bus_ctrl #(
    parameter int unsigned Width        = 8,
    parameter int unsigned SetupCycles  = 2,
    parameter int unsigned StrobeCycles = 2,
    parameter int unsigned TurnCycles   = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             we_i,
    input  logic [Width-1:0] wdata_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [Width-1:0] rdata_o,
    output logic [Width-1:0] pad_oe_o,
    output logic [Width-1:0] pad_out_o,
    input  logic [Width-1:0] pad_in_i,
    output logic             dir_o,
    output logic             strobe_o
);

    if (SetupCycles < 1 || StrobeCycles < 1 || TurnCycles < 1) begin : g_param_check
        $error("bidir_bus_ctrl: SetupCycles, StrobeCycles and TurnCycles must all be >= 1");
    end

    localparam int unsigned MaxSetStr = (SetupCycles > StrobeCycles) ? SetupCycles
                                                                      : StrobeCycles;
    localparam int unsigned MaxCycles = (MaxSetStr > TurnCycles) ? MaxSetStr : TurnCycles;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [CntW-1:0] SetupLoad  = CntW'(SetupCycles - 1);
    localparam logic [CntW-1:0] StrobeLoad = CntW'(StrobeCycles - 1);
    localparam logic [CntW-1:0] TurnLoad   = CntW'(TurnCycles - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StTurn
    } state_e;

    state_e           r_state;
    logic [CntW-1:0]  r_cnt;
    logic             r_we;
    logic             r_done;
    logic             r_dir;
    logic             r_strobe;
    logic [Width-1:0] r_pad_oe;
    logic [Width-1:0] r_pad_out;
    logic [Width-1:0] r_rdata;

    logic w_cnt_zero;
    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
            r_dir     <= 1'b0;
            r_strobe  <= 1'b0;
            r_pad_oe  <= '0;
            r_pad_out <= '0;
            r_rdata   <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_pad_oe <= '0;
                    r_strobe <= 1'b0;
                    if (req_i) begin
                        r_we     <= we_i;
                        r_dir    <= we_i;
                        r_cnt    <= SetupLoad;
                        r_state  <= StSetup;
                        r_pad_oe <= we_i ? '1 : '0;
                        if (we_i) begin
                            r_pad_out <= wdata_i;
                        end
                    end
                end
                StSetup: begin
                    if (w_cnt_zero) begin
                        r_state  <= StStrobe;
                        r_cnt    <= StrobeLoad;
                        r_strobe <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                StStrobe: begin
                    if (w_cnt_zero) begin
                        r_state  <= StHold;
                        r_strobe <= 1'b0;
                        // Capture on the edge that closes the strobe window.
                        if (!r_we) begin
                            r_rdata <= pad_in_i;
                        end
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                StHold: begin
                    if (r_we) begin
                        r_state  <= StTurn;
                        r_cnt    <= TurnLoad;
                        r_pad_oe <= '0;
                    end else begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end
                end
                StTurn: begin
                    if (w_cnt_zero) begin
                        r_state <= StIdle;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                default: begin
                    r_state  <= StIdle;
                    r_pad_oe <= '0;
                    r_strobe <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o   = (r_state == StIdle);
    assign done_o    = r_done;
    assign rdata_o   = r_rdata;
    assign pad_oe_o  = r_pad_oe;
    assign pad_out_o = r_pad_out;
    assign dir_o     = r_dir;
    assign strobe_o  = r_strobe;

    // The pads must never be driven while the external device may be driving them.
    a_no_oe_on_read: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_state != StIdle && !r_we) |-> (r_pad_oe == '0));

    a_strobe_only_in_strobe: assert property (@(posedge clk_i) disable iff (rst_i)
        r_strobe |-> (r_state == StStrobe));

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Self-checking bench for bidir_bus_ctrl: default timing and a short-setup/long-turn variant,
// table-driven transactions with a completion scoreboard plus reset and back-to-back sequences.
module tb_bidir_bus_ctrl;

    logic       clk = 1'b0;
    logic       rst     [2];
    logic       req     [2];
    logic       we      [2];
    logic [7:0] wdata   [2];
    logic [7:0] pad_in  [2];
    logic       ready   [2];
    logic       done    [2];
    logic [7:0] rdata   [2];
    logic [7:0] pad_oe  [2];
    logic [7:0] pad_out [2];
    logic       dir     [2];
    logic       strobe  [2];

    always #5 clk = ~clk;

    bidir_bus_ctrl u_dut0 (
        .clk_i     (clk),
        .rst_i     (rst[0]),
        .req_i     (req[0]),
        .we_i      (we[0]),
        .wdata_i   (wdata[0]),
        .ready_o   (ready[0]),
        .done_o    (done[0]),
        .rdata_o   (rdata[0]),
        .pad_oe_o  (pad_oe[0]),
        .pad_out_o (pad_out[0]),
        .pad_in_i  (pad_in[0]),
        .dir_o     (dir[0]),
        .strobe_o  (strobe[0])
    );

    bidir_bus_ctrl #(
        .SetupCycles  (1),
        .StrobeCycles (1),
        .TurnCycles   (3)
    ) u_dut1 (
        .clk_i     (clk),
        .rst_i     (rst[1]),
        .req_i     (req[1]),
        .we_i      (we[1]),
        .wdata_i   (wdata[1]),
        .ready_o   (ready[1]),
        .done_o    (done[1]),
        .rdata_o   (rdata[1]),
        .pad_oe_o  (pad_oe[1]),
        .pad_out_o (pad_out[1]),
        .pad_in_i  (pad_in[1]),
        .dir_o     (dir[1]),
        .strobe_o  (strobe[1])
    );

    typedef struct {
        int         d;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] pad_in;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        int         lat;
    } sb_t;

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    function automatic int setup_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int strobe_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    function automatic int turn_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    task automatic chk_reset_state(input int d);
        chk("rst_pad_oe", d, pad_oe[d], 8'h00);
        chk("rst_strobe", d, strobe[d], 1'b0);
        chk("rst_ready", d, ready[d], 1'b1);
        chk("rst_done", d, done[d], 1'b0);
        chk("rst_rdata", d, rdata[d], 8'h00);
        chk("rst_dir", d, dir[d], 1'b0);
        chk("rst_pad_out", d, pad_out[d], 8'h00);
    endtask

    // Called right after the accept edge; checks every cycle up to and including done.
    task automatic monitor(input int d, input logic w, input logic [7:0] wd);
        int  s    = setup_of(d);
        int  st   = strobe_of(d);
        int  tu   = turn_of(d);
        int  latm = w ? (s + st + tu + 2) : (s + st + 2);
        bit  seen = 1'b0;
        sb_t e;
        for (int c = 1; c <= latm + 2 && !seen; c++) begin
            @(negedge clk);
            if (c <= latm) begin
                chk("pad_oe", d, pad_oe[d], (w && c <= s + st + 1) ? 8'hFF : 8'h00);
                chk("strobe", d, strobe[d], (c > s && c <= s + st) ? 1'b1 : 1'b0);
                chk("dir", d, dir[d], w);
                chk("ready", d, ready[d], (c == latm) ? 1'b1 : 1'b0);
                if (w) chk("pad_out", d, pad_out[d], wd);
            end
            if (!w && c == s + st + 1) pad_in[d] = ~pad_in[d];
            if (done[d]) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done dut%0d @%0t: got done, expected none",
                             d, $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("latency", d, c, e.lat);
                    chk("rdata", d, rdata[d], e.rdata);
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout dut%0d @%0t: got no done, expected done by cycle %0d",
                     d, $time, latm);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
    endtask

    task automatic run_txn(input vec_t v);
        sb_t e;
        @(posedge clk);
        #1;
        req[v.d]    = 1'b1;
        we[v.d]     = v.we;
        wdata[v.d]  = v.wdata;
        pad_in[v.d] = v.pad_in;
        e.rdata     = v.exp_rdata;
        e.lat       = v.exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble inputs while busy; the latched request must not notice.
        req[v.d]   = 1'b0;
        we[v.d]    = ~v.we;
        wdata[v.d] = ~v.wdata;
        monitor(v.d, v.we, v.wdata);
        @(negedge clk);
        chk("done_pulse", v.d, done[v.d], 1'b0);
        chk("ready_after", v.d, ready[v.d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        vec_t v;
        sb_t  e;

        vecs[0] = '{d: 0, we: 1'b1, wdata: 8'h3C, pad_in: 8'h00, exp_rdata: 8'h00, exp_lat: 7};
        vecs[1] = '{d: 0, we: 1'b0, wdata: 8'h00, pad_in: 8'hA5, exp_rdata: 8'hA5, exp_lat: 6};
        vecs[2] = '{d: 0, we: 1'b1, wdata: 8'hC3, pad_in: 8'h12, exp_rdata: 8'hA5, exp_lat: 7};
        vecs[3] = '{d: 0, we: 1'b0, wdata: 8'hFF, pad_in: 8'h5A, exp_rdata: 8'h5A, exp_lat: 6};
        vecs[4] = '{d: 1, we: 1'b1, wdata: 8'h3C, pad_in: 8'h00, exp_rdata: 8'h00, exp_lat: 7};
        vecs[5] = '{d: 1, we: 1'b0, wdata: 8'h00, pad_in: 8'h96, exp_rdata: 8'h96, exp_lat: 4};
        vecs[6] = '{d: 1, we: 1'b1, wdata: 8'hFF, pad_in: 8'h33, exp_rdata: 8'h96, exp_lat: 7};
        vecs[7] = '{d: 1, we: 1'b0, wdata: 8'h81, pad_in: 8'h0F, exp_rdata: 8'h0F, exp_lat: 4};

        for (int d = 0; d < 2; d++) begin
            rst[d]    = 1'b1;
            req[d]    = 1'b0;
            we[d]     = 1'b0;
            wdata[d]  = 8'h00;
            pad_in[d] = 8'h00;
        end
        #1;
        chk_reset_state(0);
        chk_reset_state(1);
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // Write with req held high, then a read accepted in the write's done cycle.
        @(posedge clk);
        #1;
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        wdata[0] = 8'h11;
        e.rdata  = 8'h5A;
        e.lat    = 7;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        we[0]     = 1'b0;
        wdata[0]  = 8'hEE;
        pad_in[0] = 8'h77;
        e.rdata   = 8'h77;
        e.lat     = 6;
        sb_q.push_back(e);
        monitor(0, 1'b1, 8'h11);
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        monitor(0, 1'b0, 8'h00);
        @(negedge clk);
        chk("b2b_done_pulse", 0, done[0], 1'b0);
        chk("b2b_sb_empty", 0, sb_q.size(), 0);

        // Reset during the second strobe cycle of a write.
        @(posedge clk);
        #1;
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        wdata[0] = 8'h5E;
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_strobe", 0, strobe[0], 1'b1);
        chk("pre_rst_pad_oe", 0, pad_oe[0], 8'hFF);
        #2;
        rst[0] = 1'b1;
        #1;
        chk_reset_state(0);
        @(negedge clk);
        rst[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_rst_no_done", 0, done[0], 1'b0);
            chk("post_rst_ready", 0, ready[0], 1'b1);
        end
        v = '{d: 0, we: 1'b0, wdata: 8'h00, pad_in: 8'h42, exp_rdata: 8'h42, exp_lat: 6};
        run_txn(v);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
